// File: rtl/execute_stage_if.sv
// execute_stage_if: decode-to-execute operands/control, hazard-unit controls and the latched EXE/ME outputs
interface execute_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int PC_W   = 32
);
    logic              rf_we_i, mem_we_i, mem2rf_i, branch_i, check_eq_i;
    logic [3:0]        alu_op_i;
    logic              alu_src_imm_i;
    logic [DATA_W-1:0] rs1_data_i, rs2_data_i, imm_i, me_data_i, wb_data_i;
    logic [PC_W-1:0]   pc_i;
    logic [ADDR_W-1:0] rf_waddr_i;
    logic [1:0]        fwd_a_i, fwd_b_i;
    logic              latch_en, latch_clear;
    logic              rf_we_o, mem_we_o, mem2rf_o, branch_o, check_eq_o;
    logic [DATA_W-1:0] mem_wdata_o, alu_result_o;
    logic [ADDR_W-1:0] rf_waddr_o, rf_dst_hu_o;
    logic [PC_W-1:0]   pc_branch_o;
    logic              mem2rf_hu_o, busy_o;

    modport master (
        output rf_we_i, mem_we_i, mem2rf_i, branch_i, check_eq_i, alu_op_i, alu_src_imm_i,
               rs1_data_i, rs2_data_i, imm_i, me_data_i, wb_data_i, pc_i, rf_waddr_i,
               fwd_a_i, fwd_b_i, latch_en, latch_clear,
        input  rf_we_o, mem_we_o, mem2rf_o, branch_o, check_eq_o, mem_wdata_o, alu_result_o,
               rf_waddr_o, pc_branch_o, rf_dst_hu_o, mem2rf_hu_o, busy_o
    );

    modport slave (
        input  rf_we_i, mem_we_i, mem2rf_i, branch_i, check_eq_i, alu_op_i, alu_src_imm_i,
               rs1_data_i, rs2_data_i, imm_i, me_data_i, wb_data_i, pc_i, rf_waddr_i,
               fwd_a_i, fwd_b_i, latch_en, latch_clear,
        output rf_we_o, mem_we_o, mem2rf_o, branch_o, check_eq_o, mem_wdata_o, alu_result_o,
               rf_waddr_o, pc_branch_o, rf_dst_hu_o, mem2rf_hu_o, busy_o
    );
endinterface

// File: rtl/execute_stage.sv
// execute_stage: operand bypass, ALU, branch target, iterative MUL/MULHU/DIVU/REMU and the EXE/ME latch.
// Define EXE_FAST_MUL_EN to make MUL/MULHU single-cycle; only DIVU/REMU then iterate.
module execute_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int PC_W   = 32
) (
    input  logic           clk,
    input  logic           reset,
    execute_stage_if.slave bus
);
    localparam int CW = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

    typedef struct packed {
        logic              rf_we;
        logic              mem_we;
        logic              mem2rf;
        logic              branch;
        logic              check_eq;
        logic [DATA_W-1:0] mem_wdata;
        logic [DATA_W-1:0] alu_result;
        logic [ADDR_W-1:0] rf_waddr;
        logic [PC_W-1:0]   pc_branch;
    } me_t;

    md_state_t         state, state_n;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] op_a, op_b, rs2_fwd, alu_res, md_b, md_hi, md_lo, md_res;
    logic [DATA_W:0]   mul_sum, div_rs;
    logic              md_op, md_start, md_div, md_sel_hi, div_ge, busy;
    me_t               me_q, me_n;

    assign op_a    = bus.fwd_a_i == 2'd1 ? bus.me_data_i : bus.fwd_a_i == 2'd2 ? bus.wb_data_i : bus.rs1_data_i;
    assign rs2_fwd = bus.fwd_b_i == 2'd1 ? bus.me_data_i : bus.fwd_b_i == 2'd2 ? bus.wb_data_i : bus.rs2_data_i;
    assign op_b    = bus.alu_src_imm_i ? bus.imm_i : rs2_fwd;

`ifdef EXE_FAST_MUL_EN
    logic [2*DATA_W-1:0] fast_prod;
    assign fast_prod = {{DATA_W{1'b0}}, op_a} * {{DATA_W{1'b0}}, op_b};
    assign md_op     = bus.alu_op_i == 4'd12 || bus.alu_op_i == 4'd13;
`else
    assign md_op     = bus.alu_op_i inside {[4'd10:4'd13]};
`endif

    always_comb begin
        alu_res = op_a + op_b;
        case (bus.alu_op_i)
            4'd1:    alu_res = op_a - op_b;
            4'd2:    alu_res = op_a & op_b;
            4'd3:    alu_res = op_a | op_b;
            4'd4:    alu_res = op_a ^ op_b;
            4'd5:    alu_res = op_a << op_b[4:0];
            4'd6:    alu_res = op_a >> op_b[4:0];
            4'd7:    alu_res = DATA_W'($signed(op_a) >>> op_b[4:0]);
            4'd8:    alu_res = DATA_W'($signed(op_a) < $signed(op_b));
            4'd9:    alu_res = DATA_W'(op_a < op_b);
`ifdef EXE_FAST_MUL_EN
            4'd10:   alu_res = fast_prod[DATA_W-1:0];
            4'd11:   alu_res = fast_prod[2*DATA_W-1:DATA_W];
`endif
            default: alu_res = op_a + op_b;
        endcase
    end

    // DONE is never a start state, so an MD op still held on the inputs cannot retrigger
    assign md_start = state == IDLE && md_op;
    assign busy     = md_start || state == BUSY;

    always_comb begin
        state_n = IDLE;
        if (state == IDLE)
            state_n = md_op ? BUSY : IDLE;
        else if (state == BUSY && !bus.latch_clear)
            state_n = cnt == CW'(DATA_W - 1) ? DONE : BUSY;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= state == BUSY ? cnt + CW'(1) : '0;
        end
    end

    // md_hi/md_lo hold {product high, product low} for multiply and {remainder, quotient} for divide
    assign mul_sum = {1'b0, md_hi} + (md_lo[0] ? {1'b0, md_b} : '0);
    assign div_rs  = {md_hi, md_lo[DATA_W-1]};
    assign div_ge  = div_rs >= {1'b0, md_b};
    assign md_res  = md_sel_hi ? md_hi : md_lo;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_hi     <= '0;
            md_lo     <= '0;
            md_b      <= '0;
            md_div    <= 1'b0;
            md_sel_hi <= 1'b0;
        end else if (md_start) begin
            md_hi     <= '0;
            md_lo     <= op_a;
            md_b      <= op_b;
            md_div    <= bus.alu_op_i[2];
            md_sel_hi <= bus.alu_op_i[0];
        end else if (state == BUSY) begin
            md_hi <= md_div ? (div_ge ? div_rs[DATA_W-1:0] - md_b : div_rs[DATA_W-1:0]) : mul_sum[DATA_W:1];
            md_lo <= md_div ? {md_lo[DATA_W-2:0], div_ge} : {mul_sum[0], md_lo[DATA_W-1:1]};
        end
    end

    assign me_n = busy ? '0 : {bus.rf_we_i, bus.mem_we_i, bus.mem2rf_i, bus.branch_i, bus.check_eq_i,
                               rs2_fwd, state == DONE ? md_res : alu_res, bus.rf_waddr_i,
                               bus.pc_i + PC_W'(bus.imm_i)};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            me_q <= '0;
        else if (bus.latch_clear)
            me_q <= '0;
        else if (bus.latch_en)
            me_q <= me_n;
    end

    assign bus.rf_we_o      = me_q.rf_we;
    assign bus.mem_we_o     = me_q.mem_we;
    assign bus.mem2rf_o     = me_q.mem2rf;
    assign bus.branch_o     = me_q.branch;
    assign bus.check_eq_o   = me_q.check_eq;
    assign bus.mem_wdata_o  = me_q.mem_wdata;
    assign bus.alu_result_o = me_q.alu_result;
    assign bus.rf_waddr_o   = me_q.rf_waddr;
    assign bus.pc_branch_o  = me_q.pc_branch;
    assign bus.rf_dst_hu_o  = bus.rf_waddr_i;
    assign bus.mem2rf_hu_o  = bus.mem2rf_i;
    assign bus.busy_o       = busy;
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage of the 5-stage pipeline. Sits between decode and memory_stage, and drives memory_stage's `*_i` inputs through its own EXE/ME latches.
- Resolves operand bypass, computes the ALU result and branch target, and runs an iterative unsigned multiply/divide unit.
- Stalls the front end through `busy_o` while a multi-cycle operation is in flight.

Parameters:
- DATA_W, 32, datapath width
- ADDR_W, 5, register-file address width
- PC_W, 32, program-counter width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- rf_we_i, mem_we_i, mem2rf_i, branch_i, check_eq_i  in  1 each  decode control
- alu_op_i  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL, 11 MULHU, 12 DIVU, 13 REMU; 14/15 behave as ADD
- alu_src_imm_i  in  1  operand B = imm_i when 1
- rs1_data_i, rs2_data_i, imm_i  in  DATA_W  register and immediate operands
- pc_i  in  PC_W  instruction PC
- rf_waddr_i  in  ADDR_W  destination register
- fwd_a_i, fwd_b_i  in  2 each  0 = RF, 1 = me_data_i, 2 = wb_data_i, 3 = RF
- me_data_i, wb_data_i  in  DATA_W  bypass data from ME and WB
- latch_en, latch_clear  in  1 each  EXE/ME latch control from the hazard unit
- rf_we_o, mem_we_o, mem2rf_o, branch_o, check_eq_o  out  1 each  latched control to ME
- mem_wdata_o, alu_result_o  out  DATA_W  latched to ME
- rf_waddr_o  out  ADDR_W  latched to ME
- pc_branch_o  out  PC_W  latched, pc_i + imm_i
- rf_dst_hu_o  out  ADDR_W  unlatched rf_waddr_i, for the hazard unit
- mem2rf_hu_o  out  1  unlatched mem2rf_i, for load-use detection
- busy_o  out  1  multiply/divide in progress; hazard unit must hold FE/DE

Behaviour:
- Operand A is the forwarded rs1. Operand B is imm_i if alu_src_imm_i, else the forwarded rs2. mem_wdata is always the forwarded rs2.
- Shift amount is B[4:0]. SLT is signed, SLTU unsigned, result 0 or 1. All arithmetic wraps modulo 2^DATA_W.
- Latches: async reset gives every `*_o` = 0. latch_clear has priority and loads 0. Otherwise, if latch_en, load the next value; else hold.
- MD FSM states: IDLE, BUSY, DONE. Counter is clog2(DATA_W)+1 bits.
- IDLE with alu_op in 10..13:
  - capture A and B; busy_o = 1 combinationally; go to BUSY with counter = 0.
- BUSY:
  - one shift-add (MUL/MULHU, 2·DATA_W-bit product) or one restoring-divide step per cycle;
  - go to DONE when counter reaches DATA_W-1, i.e. exactly DATA_W BUSY cycles;
  - busy_o = 1.
- DONE:
  - busy_o = 0; the MD result is selected as alu_result; go to IDLE unconditionally.
  - DONE never re-detects the op still on the inputs.
- Latency: an MD op occupies EXE for DATA_W+2 cycles. Its result enters the ME latch at the end of the DONE cycle.
- While busy_o = 1, the EXE/ME latch loads a bubble (all control 0, data 0) whenever latch_en = 1, so ME never sees partial results.
- Non-MD ops in IDLE: single cycle, busy_o = 0.
- MUL returns the low product half; MULHU the high half.
- Divide by zero: DIVU returns all ones; REMU returns the dividend. Both still take full latency.
- latch_clear in BUSY or DONE (flush): FSM goes to IDLE next cycle, busy_o drops next cycle, and the result is discarded.
- Reset asserted mid-operation: FSM goes to IDLE and the counter to 0 asynchronously.

Optional Feature:
- Macro: EXE_FAST_MUL_EN.
- Defined: MUL and MULHU are computed combinationally in one cycle with busy_o = 0 and never enter the FSM. Only DIVU/REMU are iterative.
- Undefined: all four MD ops use the iterative FSM with the latency above.

Test Plan:
1. Reset low for 3 cycles, release; ADD A=5, B=imm 7 -> next cycle alu_result_o = 12, busy_o never 1, all other outputs 0 during reset.
2. fwd_a_i = 1 with me_data_i = 0x10, fwd_b_i = 2 with wb_data_i = 3, rs1/rs2 = 0xFF, op SUB -> alu_result_o = 0xD; mem_wdata_o = 3.
3. DIVU 100/7 held with latch_en = 1 -> busy_o high 33 cycles, bubbles in ME meanwhile, alu_result_o = 14 after cycle 34. REMU -> 2.
4. DIVU 0x1234 by 0 -> all ones; REMU 0x1234 by 0 -> 0x1234.
5. MULHU 0xFFFFFFFF × 2 -> 1; MUL -> 0xFFFFFFFE. Without the macro busy_o is high 33 cycles; with EXE_FAST_MUL_EN busy_o stays 0.
6. latch_clear pulse at BUSY cycle 10 of DIVU -> busy_o low next cycle, ME latch 0. Reset asserted mid-BUSY -> FSM IDLE and outputs 0 immediately.
